// File: rtl/counter_pkg.sv
// Shared helpers for the up counter family: parameter sanity checks and load clamping.
// Combinational only; no clocked state lives here.
package counter_pkg;

  function automatic bit max_count_ok(input int width, input longint max_count);
    return (width >= 1) && (max_count >= 1) &&
           (max_count <= ((64'sd1 <<< width) - 64'sd1));
  endfunction

  function automatic bit prescale_ok(input int prescale);
    return prescale >= 1;
  endfunction

  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/up_counter_prescaler.sv
// Divides enabled cycles into a one-cycle tick every PRESCALE enabled edges.
// tick is combinational from the current count; en low pauses without resetting.
module up_counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic zero,
  output logic tick
);

  if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
    $error("up_counter_prescaler: PRESCALE must be >= 1");
  end

  if (PRESCALE == 1) begin : g_direct
    logic w_unused;
    assign w_unused = ^{clk, reset, zero};
    assign tick     = en;
  end else begin : g_div
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] r_pcnt;
    logic          w_last;

    assign w_last = (r_pcnt == PW'(PRESCALE - 1));
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
      if (reset || zero) begin
        r_pcnt <= '0;
      end else if (en) begin
        r_pcnt <= w_last ? '0 : r_pcnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/up_counter.sv
// Modulo-(MAX_COUNT+1) up counter with clear/load, optional prescaler, tc, wrap pulse and sticky overflow.
// Edge priority is reset > clear > load > count; q updates on the same edge a tick is seen.
module up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             overflow
);

  if (!max_count_ok(WIDTH, MAX_COUNT)) begin : g_bad_max
    $error("up_counter: MAX_COUNT must lie in 1 .. 2**WIDTH-1");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;
  logic             w_tick;
  logic             w_at_max;
  logic [WIDTH-1:0] w_load_q;

  assign w_at_max = (r_q == WIDTH'(MAX_COUNT));
  assign w_load_q = WIDTH'(clamp_load(32'(load_val), 32'(MAX_COUNT)));

  up_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .zero  (clear | load),
    .tick  (w_tick)
  );

  // Explicit wrap select keeps MAX_COUNT < 2**WIDTH-1 correct; the full-range case matches natural rollover.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (load) begin
      r_q    <= w_load_q;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_tick) begin
        if (w_at_max) begin
          r_q    <= '0;
          r_wrap <= 1'b1;
          r_ovf  <= 1'b1;
        end else begin
          r_q <= r_q + WIDTH'(1);
        end
      end
    end
  end

  assign q        = r_q;
  assign tc       = w_at_max;
  assign wrap     = r_wrap;
  assign overflow = r_ovf;

endmodule
